axis_uart_mem_cmd_bridge: RTL and testbench

- Framed command engine between the byte-stream side of the UART (AXI-Stream RX/TX) and one generic memory port, e.g. port B of bram_true_dp.
- Supersedes the fixed bridge controller:
  - parametrised burst reads and writes;
  - configurable address and data byte counts;
  - per-frame status byte;
  - inter-byte timeout recovery.
- Sits between the UART PHY and the BRAM. The host drives memory via the serial link.

---
 rtl/axis_uart_bridge_pkg.sv | 26 ++
 rtl/axis_uart_word_shifter.sv | 65 ++++++
 rtl/axis_uart_mem_cmd_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_axis_uart_mem_cmd_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_uart_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-memory command bridge.
package axis_uart_bridge_pkg;

  // Frame opcodes sent by the host.
  localparam logic [7:0] OPC_WRITE = 8'h01;
  localparam logic [7:0] OPC_READ  = 8'h02;

  // Per-frame status bytes returned to the host.
  localparam logic [7:0] ST_OK  = 8'hA5;
  localparam logic [7:0] ST_ERR = 8'hEE;

  // Frame engine states.
  typedef enum logic [3:0] {
    S_OPC,
    S_LEN,
    S_ADDR,
    S_WDAT,
    S_WR,
    S_RREQ,
    S_RWAIT,
    S_RSEND,
    S_ACK,
    S_ERR
  } state_e;

endpackage

// File: rtl/axis_uart_word_shifter.sv
// Byte-wide shift register with a byte counter. Assembles a word MSB first
// from incoming bytes, or serialises a loaded word MSB first.
module axis_uart_word_shifter #(
  parameter int BYTE_NUM   = 4,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           load_i,
  input  logic [BYTE_NUM*BYTE_WIDTH-1:0] load_data_i,
  input  logic                           shift_in_i,
  input  logic [BYTE_WIDTH-1:0]          byte_i,
  input  logic                           shift_out_i,
  output logic [BYTE_NUM*BYTE_WIDTH-1:0] data_o,
  output logic [BYTE_NUM*BYTE_WIDTH-1:0] data_next_o,
  output logic [BYTE_WIDTH-1:0]          byte_o,
  output logic                           last_o
);

  localparam int W     = BYTE_NUM * BYTE_WIDTH;
  localparam int CNT_W = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_NUM - 1);

  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_step;

  assign data_next_o = (data_q << BYTE_WIDTH) | W'(byte_i);
  assign cnt_step    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign data_o      = data_q;
  assign byte_o      = data_q[W-1 -: BYTE_WIDTH];
  assign last_o      = (cnt_q == CNT_LAST);

  // Select the next register contents; clear beats load beats shifting.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
    end else if (shift_in_i) begin
      data_d = data_next_o;
      cnt_d  = cnt_step;
    end else if (shift_out_i) begin
      data_d = data_q << BYTE_WIDTH;
      cnt_d  = cnt_step;
    end
  end

  // Register the word and byte counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_uart_mem_cmd_bridge.sv
// Framed command engine: parses WRITE/READ frames from the UART RX stream,
// drives one memory port, and answers with read data and a status byte.
module axis_uart_mem_cmd_bridge
  import axis_uart_bridge_pkg::*;
#(
  parameter int BYTE_NUM       = 4,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int ADDR_BYTES     = (ADDR_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH,
  parameter int MAX_BURST      = 16,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [BYTE_WIDTH-1:0]          s_axis_tdata_i,
  input  logic                           s_axis_tvalid_i,
  output logic                           s_axis_tready_o,
  output logic [BYTE_WIDTH-1:0]          m_axis_tdata_o,
  output logic                           m_axis_tvalid_o,
  input  logic                           m_axis_tready_i,
  output logic                           mem_en_o,
  output logic [BYTE_NUM-1:0]            mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [BYTE_NUM*BYTE_WIDTH-1:0] mem_data_o,
  input  logic [BYTE_NUM*BYTE_WIDTH-1:0] mem_data_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int WORD_W    = BYTE_NUM * BYTE_WIDTH;
  localparam int ADDR_SH_W = ADDR_BYTES * BYTE_WIDTH;
  localparam int WAIT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
  localparam logic [BYTE_WIDTH:0]   MAX_LEN   = (BYTE_WIDTH + 1)'(MAX_BURST);
  localparam logic [BYTE_WIDTH-1:0] B_WRITE   = BYTE_WIDTH'(OPC_WRITE);
  localparam logic [BYTE_WIDTH-1:0] B_READ    = BYTE_WIDTH'(OPC_READ);

  state_e                  state_q, state_d;
  logic                    is_rd_q, is_rd_d;
  logic [BYTE_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    err_q;

  logic                    rx_ready, rx_fire, tx_valid, tx_fire, timed, tmo_hit;
  logic [ADDR_SH_W-1:0]    addr_next;
  logic [ADDR_SH_W-1:0]    addr_data_unused;
  logic [BYTE_WIDTH-1:0]   addr_byte_unused;
  logic                    addr_last;
  logic [WORD_W-1:0]       word_q;
  logic [WORD_W-1:0]       word_next_unused;
  logic [BYTE_WIDTH-1:0]   tx_byte;
  logic                    word_last;

  assign rx_ready = !rst_i && (state_q inside {S_OPC, S_LEN, S_ADDR, S_WDAT});
  assign rx_fire  = s_axis_tvalid_i && rx_ready;
  assign tx_valid = (state_q inside {S_RSEND, S_ACK, S_ERR});
  assign tx_fire  = tx_valid && m_axis_tready_i;
  assign timed    = (state_q inside {S_LEN, S_ADDR, S_WDAT});
  assign tmo_hit  = TMO_EN && timed && !rx_fire && (tmo_q == TMO_LAST);

  axis_uart_word_shifter #(
    .BYTE_NUM   (ADDR_BYTES),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_addr_shifter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (state_q == S_OPC),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_in_i  (rx_fire && (state_q == S_ADDR)),
    .byte_i      (s_axis_tdata_i),
    .shift_out_i (1'b0),
    .data_o      (addr_data_unused),
    .data_next_o (addr_next),
    .byte_o      (addr_byte_unused),
    .last_o      (addr_last)
  );

  axis_uart_word_shifter #(
    .BYTE_NUM   (BYTE_NUM),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_data_shifter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (state_q == S_OPC),
    .load_i      ((state_q == S_RWAIT) && (wait_q == WAIT_LAST)),
    .load_data_i (mem_data_i),
    .shift_in_i  (rx_fire && (state_q == S_WDAT)),
    .byte_i      (s_axis_tdata_i),
    .shift_out_i (tx_fire && (state_q == S_RSEND)),
    .data_o      (word_q),
    .data_next_o (word_next_unused),
    .byte_o      (tx_byte),
    .last_o      (word_last)
  );

  // Frame sequencing: next state, burst bookkeeping and the idle timeout.
  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wait_d  = '0;
    tmo_d   = (TMO_EN && timed && !rx_fire) ? tmo_q + 1'b1 : '0;
    case (state_q)
      S_OPC: begin
        if (rx_fire) begin
          if (s_axis_tdata_i == B_WRITE) begin
            state_d = S_LEN;
            is_rd_d = 1'b0;
          end else if (s_axis_tdata_i == B_READ) begin
            state_d = S_LEN;
            is_rd_d = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LEN: begin
        if (rx_fire) begin
          if ({1'b0, s_axis_tdata_i} >= MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            len_d   = s_axis_tdata_i;
            state_d = S_ADDR;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_ADDR: begin
        if (rx_fire && addr_last) begin
          addr_d  = addr_next[ADDR_WIDTH-1:0];
          state_d = is_rd_q ? S_RREQ : S_WDAT;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_WDAT: begin
        if (rx_fire && word_last) begin
          state_d = S_WR;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_WR: begin
        addr_d = addr_q + 1'b1;
        if (len_q == '0) begin
          state_d = S_ACK;
        end else begin
          len_d   = len_q - 1'b1;
          state_d = S_WDAT;
        end
      end
      S_RREQ: begin
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_RSEND;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RSEND: begin
        if (tx_fire && word_last) begin
          addr_d = addr_q + 1'b1;
          if (len_q == '0) begin
            state_d = S_ACK;
          end else begin
            len_d   = len_q - 1'b1;
            state_d = S_RREQ;
          end
        end
      end
      S_ACK, S_ERR: begin
        if (tx_fire) begin
          state_d = S_OPC;
        end
      end
      default: begin
        state_d = S_OPC;
      end
    endcase
  end

  // Engine registers; the error flag is high only in the first S_ERR cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_OPC;
      is_rd_q <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      err_q   <= (state_d == S_ERR) && (state_q != S_ERR);
    end
  end

  // Response byte mux; held constant by the state while the TX side stalls.
  always_comb begin
    m_axis_tdata_o = '0;
    case (state_q)
      S_RSEND: m_axis_tdata_o = tx_byte;
      S_ACK:   m_axis_tdata_o = BYTE_WIDTH'(ST_OK);
      S_ERR:   m_axis_tdata_o = BYTE_WIDTH'(ST_ERR);
      default: m_axis_tdata_o = '0;
    endcase
  end

  assign s_axis_tready_o = rx_ready;
  assign m_axis_tvalid_o = tx_valid;
  assign mem_en_o        = (state_q == S_WR) || (state_q == S_RREQ);
  assign mem_wr_en_o     = {BYTE_NUM{state_q == S_WR}};
  assign mem_addr_o      = addr_q;
  assign mem_data_o      = word_q;
  assign busy_o          = (state_q != S_OPC);
  assign err_o           = err_q;

endmodule

// File: tb/tb_axis_uart_mem_cmd_bridge.sv
// Scoreboard bench for the UART-to-memory command bridge.
module tb_axis_uart_mem_cmd_bridge;

  localparam int TMO = 50;

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [31:0] data;
  } access_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sTdata = 8'h00;
  logic        sTvalid = 1'b0;
  logic        sTready;
  logic [7:0]  mTdata;
  logic        mTvalid;
  logic        mTready = 1'b1;
  logic        memEn;
  logic [3:0]  memWrEn;
  logic [31:0] memAddr;
  logic [31:0] memDataOut;
  logic [31:0] memDataIn = 32'h0;
  logic        busy;
  logic        err;

  access_t     accQ[$];
  logic [7:0]  txQ[$];
  logic [31:0] wordQ[$];
  logic [31:0] memModel [logic [31:0]];

  int          total = 0;
  int          bad = 0;
  int          errCount = 0;
  int          txMode = 0;
  logic        stallPending = 1'b0;
  logic [7:0]  stallData = 8'h00;

  axis_uart_mem_cmd_bridge #(
    .MAX_BURST      (16),
    .RD_LATENCY     (1),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i           (clock),
    .rst_i           (reset),
    .s_axis_tdata_i  (sTdata),
    .s_axis_tvalid_i (sTvalid),
    .s_axis_tready_o (sTready),
    .m_axis_tdata_o  (mTdata),
    .m_axis_tvalid_o (mTvalid),
    .m_axis_tready_i (mTready),
    .mem_en_o        (memEn),
    .mem_wr_en_o     (memWrEn),
    .mem_addr_o      (memAddr),
    .mem_data_o      (memDataOut),
    .mem_data_i      (memDataIn),
    .busy_o          (busy),
    .err_o           (err)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Record an event that should not have happened at all.
  task automatic reportFail(input string name, input logic [63:0] actual);
    total++;
    bad++;
    $display("[TB] FAIL %s: got 0x%0h, expected none", name, actual);
  endtask

  // Single-port memory model with one cycle of read latency.
  always @(posedge clock) begin
    if (memEn) begin
      if (|memWrEn) memModel[memAddr] = memDataOut;
      else memDataIn <= memModel.exists(memAddr) ? memModel[memAddr] : 32'h0;
    end
  end

  // TX ready pattern: 0 = always ready, 1 = toggling, 2 = stalled.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (txMode)
        0:       mTready = 1'b1;
        1:       mTready = ~mTready;
        default: mTready = 1'b0;
      endcase
    end
  end

  // Monitor: pop and compare memory accesses and TX bytes as they appear.
  always @(negedge clock) begin
    access_t a;
    if (memEn) begin
      if (accQ.size() == 0) begin
        reportFail("unexpected mem access", {32'h0, memAddr});
      end else begin
        a = accQ.pop_front();
        checkOutput("mem access is write", {63'h0, |memWrEn}, {63'h0, a.isWrite});
        checkOutput("mem addr", {32'h0, memAddr}, {32'h0, a.addr});
        if (a.isWrite) begin
          checkOutput("mem wr_en", {60'h0, memWrEn}, 64'hF);
          checkOutput("mem wdata", {32'h0, memDataOut}, {32'h0, a.data});
        end
      end
    end
    if (mTvalid) begin
      if (stallPending) checkOutput("tx data stable under stall", {56'h0, mTdata}, {56'h0, stallData});
      if (mTready) begin
        stallPending = 1'b0;
        if (txQ.size() == 0) reportFail("unexpected tx byte", {56'h0, mTdata});
        else checkOutput("tx byte", {56'h0, mTdata}, {56'h0, txQ.pop_front()});
      end else begin
        stallPending = 1'b1;
        stallData = mTdata;
      end
    end else begin
      stallPending = 1'b0;
    end
    if (err) errCount++;
  end

  // Offer one RX byte and hold it until the bridge accepts it.
  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    sTdata = b;
    sTvalid = 1'b1;
    @(negedge clock);
    while (!sTready && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 500) reportFail("rx accept timeout", {56'h0, b});
    @(posedge clock);
    #1;
    sTvalid = 1'b0;
  endtask

  // Send a full frame header plus any queued write words, MSB first.
  task automatic applyStimulus(input logic [7:0] opc, input logic [7:0] len, input logic [31:0] addr);
    logic [31:0] w;
    sendByte(opc);
    sendByte(len);
    for (int i = 3; i >= 0; i--) sendByte(addr[i*8 +: 8]);
    if (opc == 8'h01) begin
      while (wordQ.size() > 0) begin
        w = wordQ.pop_front();
        for (int i = 3; i >= 0; i--) sendByte(w[i*8 +: 8]);
      end
    end
  endtask

  // Wait until every expectation is consumed and the bridge is idle.
  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while ((txQ.size() != 0 || accQ.size() != 0 || busy) && n < maxCycles) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= maxCycles) reportFail("drain timeout, items left", 64'(txQ.size() + accQ.size()));
  endtask

  task automatic expWrite(input logic [31:0] addr, input logic [31:0] data);
    access_t a;
    a.isWrite = 1'b1;
    a.addr = addr;
    a.data = data;
    accQ.push_back(a);
    wordQ.push_back(data);
  endtask

  task automatic expRead(input logic [31:0] addr);
    access_t a;
    a.isWrite = 1'b0;
    a.addr = addr;
    a.data = 32'h0;
    accQ.push_back(a);
  endtask

  task automatic expTx(input logic [31:0] word);
    for (int i = 3; i >= 0; i--) txQ.push_back(word[i*8 +: 8]);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " tready"}, {63'h0, sTready}, 64'h0);
    checkOutput({tag, " tvalid"}, {63'h0, mTvalid}, 64'h0);
    checkOutput({tag, " tdata"}, {56'h0, mTdata}, 64'h0);
    checkOutput({tag, " mem_en"}, {63'h0, memEn}, 64'h0);
    checkOutput({tag, " wr_en"}, {60'h0, memWrEn}, 64'h0);
    checkOutput({tag, " mem_addr"}, {32'h0, memAddr}, 64'h0);
    checkOutput({tag, " mem_data"}, {32'h0, memDataOut}, 64'h0);
    checkOutput({tag, " busy"}, {63'h0, busy}, 64'h0);
    checkOutput({tag, " err"}, {63'h0, err}, 64'h0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    int e0;
    int n;
    memModel[32'h11] = 32'hCAFEF00D;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("in reset");
    reset = 1'b0;
    #1;
    checkOutput("after reset tready", {63'h0, sTready}, 64'h1);
    checkOutput("after reset busy", {63'h0, busy}, 64'h0);
    @(posedge clock);
    #1;

    // Single-word write with strobe latency check.
    $display("[TB] single word write");
    expWrite(32'h10, 32'hDEADBEEF);
    txQ.push_back(8'hA5);
    applyStimulus(8'h01, 8'h00, 32'h10);
    checkOutput("write strobe next cycle mem_en", {63'h0, memEn}, 64'h1);
    checkOutput("write strobe next cycle wr_en", {60'h0, memWrEn}, 64'hF);
    waitDrain(200);

    // Four-word write wrapping through the top of the address space.
    $display("[TB] burst write with address wrap");
    expWrite(32'hFFFFFFFE, 32'h11223344);
    expWrite(32'hFFFFFFFF, 32'h55667788);
    expWrite(32'h00000000, 32'h99AABBCC);
    expWrite(32'h00000001, 32'hDDEEFF00);
    txQ.push_back(8'hA5);
    applyStimulus(8'h01, 8'h03, 32'hFFFFFFFE);
    waitDrain(300);

    // Two-word read with a toggling TX ready.
    $display("[TB] burst read with TX stalls");
    txMode = 1;
    expRead(32'h10);
    expRead(32'h11);
    expTx(32'hDEADBEEF);
    expTx(32'hCAFEF00D);
    txQ.push_back(8'hA5);
    applyStimulus(8'h02, 8'h01, 32'h10);
    checkOutput("read strobe next cycle mem_en", {63'h0, memEn}, 64'h1);
    checkOutput("read strobe wr_en", {60'h0, memWrEn}, 64'h0);
    @(posedge clock);
    #1;
    checkOutput("tvalid one cycle after read strobe", {63'h0, mTvalid}, 64'h0);
    @(posedge clock);
    #1;
    checkOutput("tvalid two cycles after read strobe", {63'h0, mTvalid}, 64'h1);
    waitDrain(300);
    txMode = 0;

    // Bad opcode, then a normal read.
    $display("[TB] bad opcode");
    e0 = errCount;
    txQ.push_back(8'hEE);
    sendByte(8'h7F);
    waitDrain(100);
    checkOutput("err pulse count bad opcode", 64'(errCount - e0), 64'h1);
    expRead(32'hFFFFFFFF);
    expTx(32'h55667788);
    txQ.push_back(8'hA5);
    applyStimulus(8'h02, 8'h00, 32'hFFFFFFFF);
    waitDrain(200);

    // Burst length one past the maximum.
    $display("[TB] oversize burst");
    e0 = errCount;
    txQ.push_back(8'hEE);
    sendByte(8'h01);
    sendByte(8'h10);
    waitDrain(100);
    checkOutput("err pulse count oversize", 64'(errCount - e0), 64'h1);

    // Inter-byte timeout with a half-received address.
    $display("[TB] inter-byte timeout");
    e0 = errCount;
    txQ.push_back(8'hEE);
    sendByte(8'h02);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    n = 1;
    while (!mTvalid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    total++;
    if (n < TMO - 1 || n > TMO + 2) begin
      bad++;
      $display("[TB] FAIL timeout latency: got %0d cycles, expected %0d..%0d", n, TMO - 1, TMO + 2);
    end
    waitDrain(100);
    checkOutput("err pulse count timeout", 64'(errCount - e0), 64'h1);

    // Reset while a read word waits on a stalled TX side.
    $display("[TB] reset during read send");
    txMode = 2;
    @(posedge clock);
    #1;
    expRead(32'h0);
    applyStimulus(8'h02, 8'h03, 32'h0);
    n = 0;
    while (!mTvalid && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 50) reportFail("read send never started", 64'(n));
    repeat (2) @(posedge clock);
    #1;
    checkOutput("stalled in send busy", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkAllZero("mid-burst reset");
    reset = 1'b0;
    #1;
    checkOutput("post reset tready", {63'h0, sTready}, 64'h1);
    checkOutput("aborted read access consumed", 64'(accQ.size()), 64'h0);
    txMode = 0;
    @(posedge clock);
    #1;
    expWrite(32'h20, 32'h12345678);
    txQ.push_back(8'hA5);
    applyStimulus(8'h01, 8'h00, 32'h20);
    waitDrain(200);

    checkOutput("tx queue empty at end", 64'(txQ.size()), 64'h0);
    checkOutput("access queue empty at end", 64'(accQ.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
